// File: rtl/if_fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC select codes,
// fetch FSM states and the default reset vector.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    SEL_PC4 = 2'b00,
    SEL_BR  = 2'b01,
    SEL_J   = 2'b10,
    SEL_JR  = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_DRAIN,
    ST_HALT
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/if_fetch_npc.sv
// Combinational next-PC unit: decides whether ID redirects fetch and computes
// the target. Without ALIGN_CHECK_EN the target is forced word aligned.
module if_fetch_npc
  import if_fetch_pkg::*;
(
  input  logic        stall,
  input  logic [1:0]  redir_sel,
  input  logic        redir_taken,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] id_rs_val,
  output logic        redir,
  output logic [31:0] target
);

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] raw_target;
  logic        redir_req;

  always_comb begin
    pc_plus4   = id_pc + 32'd4;
    br_target  = pc_plus4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
    raw_target = pc_plus4;
    redir_req  = 1'b0;
    case (pc_sel_e'(redir_sel))
      SEL_PC4: begin
        raw_target = pc_plus4;
        redir_req  = 1'b0;
      end
      SEL_BR: begin
        raw_target = br_target;
        redir_req  = redir_taken;
      end
      SEL_J: begin
        raw_target = {pc_plus4[31:28], id_index26, 2'b00};
        redir_req  = 1'b1;
      end
      SEL_JR: begin
        raw_target = id_rs_val;
        redir_req  = 1'b1;
      end
      default: begin
        raw_target = pc_plus4;
        redir_req  = 1'b0;
      end
    endcase
    redir = redir_req && !stall;
`ifdef ALIGN_CHECK_EN
    target = raw_target;
`else
    target = {raw_target[31:2], 2'b00};
`endif
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, valid-handshake imem fetch, IF/ID
// register with one-entry skid. Optional ALIGN_CHECK_EN traps misaligned redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  redir_sel,
  input  logic        redir_taken,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] id_rs_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        fetch_err
);

  fetch_state_e state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         ifv_d;
  logic [31:0]  ifi_d, ifp_d;
  logic         skid_valid, skv_d;
  logic [31:0]  skid_instr, ski_d, skid_pc, skp_d;
  logic         err_d;
  logic         req_c;
  logic         misalign;
  logic         redir;
  logic [31:0]  target;

  if_fetch_npc u_npc (
    .stall       (stall),
    .redir_sel   (redir_sel),
    .redir_taken (redir_taken),
    .id_pc       (id_pc),
    .id_imm16    (id_imm16),
    .id_index26  (id_index26),
    .id_rs_val   (id_rs_val),
    .redir       (redir),
    .target      (target)
  );

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    addr_d    = addr_q;
    ifv_d     = if_id_valid;
    ifi_d     = if_id_instr;
    ifp_d     = if_id_pc;
    skv_d     = skid_valid;
    ski_d     = skid_instr;
    skp_d     = skid_pc;
    err_d     = fetch_err;
    req_c     = 1'b0;
    imem_addr = pc;
    misalign  = 1'b0;
`ifdef ALIGN_CHECK_EN
    misalign  = redir && (target[1:0] != 2'b00);
`endif
    case (state)
      ST_FETCH: begin
        imem_addr = pc;
        if (!stall) begin
          if (skid_valid) begin
            // Skid drains into IF/ID; no new request until it is empty.
            ifv_d = 1'b1;
            ifi_d = skid_instr;
            ifp_d = skid_pc;
            skv_d = 1'b0;
            if (redir) begin
              ifv_d = 1'b0;
              pc_d  = target;
            end
          end else begin
            req_c  = 1'b1;
            addr_d = pc;
            if (redir) begin
              pc_d  = target;
              ifv_d = 1'b0;
              if (!imem_valid) state_d = ST_DRAIN;
            end else if (imem_valid) begin
              ifv_d = 1'b1;
              ifi_d = imem_rdata;
              ifp_d = pc;
              pc_d  = pc + 32'd4;
            end else begin
              ifv_d   = 1'b0;
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        req_c     = 1'b1;
        imem_addr = addr_q;
        if (redir) begin
          // A response landing with the redirect is simply dropped; nothing left to drain.
          pc_d    = target;
          ifv_d   = 1'b0;
          state_d = imem_valid ? ST_FETCH : ST_DRAIN;
        end else if (imem_valid) begin
          pc_d    = pc + 32'd4;
          state_d = ST_FETCH;
          if (stall) begin
            skv_d = 1'b1;
            ski_d = imem_rdata;
            skp_d = addr_q;
          end else begin
            ifv_d = 1'b1;
            ifi_d = imem_rdata;
            ifp_d = addr_q;
          end
        end else if (!stall) begin
          ifv_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        req_c     = 1'b1;
        imem_addr = addr_q;
        if (redir) pc_d = target;
        if (imem_valid) state_d = ST_FETCH;
      end
      ST_HALT: begin
        req_c = 1'b0;
      end
      default: state_d = ST_FETCH;
    endcase
    if (misalign) begin
      err_d   = 1'b1;
      ifv_d   = 1'b0;
      skv_d   = 1'b0;
      pc_d    = pc;
      state_d = ST_HALT;
    end
  end

  assign imem_req = rst_n && req_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      addr_q      <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      addr_q      <= addr_d;
      if_id_valid <= ifv_d;
      if_id_instr <= ifi_d;
      if_id_pc    <= ifp_d;
      skid_valid  <= skv_d;
      skid_instr  <= ski_d;
      skid_pc     <= skp_d;
      fetch_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: table of per-cycle vectors on zero-wait memory,
// plus hand sequences for wait-state redirect, skid under stall and alignment.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  redir_sel;
  logic        redir_taken;
  logic [31:0] id_pc;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [31:0] id_rs_val;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  int unsigned wait_n = 0;
  int unsigned cnt    = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redir_sel   (redir_sel),
    .redir_taken (redir_taken),
    .id_pc       (id_pc),
    .id_imm16    (id_imm16),
    .id_index26  (id_index26),
    .id_rs_val   (id_rs_val),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .fetch_err   (fetch_err)
  );

  // Memory model: answers after wait_n cycles of held request; word = ~address.
  assign imem_valid = imem_req && (cnt == wait_n);
  assign imem_rdata = ~imem_addr;
  always @(posedge clk) cnt <= (!imem_req || imem_valid) ? 0 : cnt + 1;

  typedef struct {
    logic        stall;
    logic [1:0]  sel;
    logic        taken;
    logic [31:0] id_pc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(logic st, logic [1:0] sel, logic tk, logic [31:0] ipc,
                               logic [15:0] imm, logic [25:0] idx, logic [31:0] rs,
                               logic er, logic [31:0] ea, logic ev, logic [31:0] ep);
    vec_t v;
    v.stall = st; v.sel = sel; v.taken = tk; v.id_pc = ipc; v.imm = imm;
    v.idx = idx; v.rs = rs; v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redir_sel = 2'b00; redir_taken = 1'b0;
    id_pc = '0; id_imm16 = '0; id_index26 = '0; id_rs_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int bound, output logic found);
    found = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk); #1;
      if (if_id_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    vecs[0]  = mkv(0, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    1, 32'h0000_3000, 0, 32'h0);
    vecs[1]  = mkv(0, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    1, 32'h0000_3004, 1, 32'h0000_3000);
    vecs[2]  = mkv(0, 2'b01, 1, 32'h0000_3008, 16'hFFFE, 26'h0,       32'h0,    1, 32'h0000_3008, 1, 32'h0000_3004);
    vecs[3]  = mkv(0, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    1, 32'h0000_3004, 0, 32'h0);
    vecs[4]  = mkv(0, 2'b01, 0, 32'h0000_3008, 16'hFFFE, 26'h0,       32'h0,    1, 32'h0000_3008, 1, 32'h0000_3004);
    vecs[5]  = mkv(0, 2'b10, 0, 32'h0000_3008, 16'h0,    26'h400,     32'h0,    1, 32'h0000_300C, 1, 32'h0000_3008);
    vecs[6]  = mkv(0, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    1, 32'h0000_1000, 0, 32'h0);
    vecs[7]  = mkv(1, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    0, 32'h0000_1004, 1, 32'h0000_1000);
    vecs[8]  = mkv(1, 2'b11, 0, 32'h0,         16'h0,    26'h0,       32'h5000, 0, 32'h0000_1004, 1, 32'h0000_1000);
    vecs[9]  = mkv(0, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    1, 32'h0000_1004, 1, 32'h0000_1000);
    vecs[10] = mkv(0, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    1, 32'h0000_1008, 1, 32'h0000_1004);
    vecs[11] = mkv(0, 2'b10, 0, 32'hF000_0000, 16'h0,    26'h3FF_FFFF, 32'h0,   1, 32'h0000_100C, 1, 32'h0000_1008);
    vecs[12] = mkv(0, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    1, 32'hFFFF_FFFC, 0, 32'h0);
    vecs[13] = mkv(0, 2'b01, 1, 32'hFFFF_FFFC, 16'h0001, 26'h0,       32'h0,    1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
    vecs[14] = mkv(0, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    1, 32'h0000_0004, 0, 32'h0);
    vecs[15] = mkv(0, 2'b00, 0, 32'h0,         16'h0,    26'h0,       32'h0,    1, 32'h0000_0008, 1, 32'h0000_0004);

    // Zero-wait memory, table-driven.
    wait_n = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].stall; redir_sel = vecs[i].sel; redir_taken = vecs[i].taken;
      id_pc = vecs[i].id_pc; id_imm16 = vecs[i].imm; id_index26 = vecs[i].idx;
      id_rs_val = vecs[i].rs;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_v});
      if (vecs[i].e_v) begin
        chk($sformatf("v%0d_pc", i), if_id_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_instr", i), if_id_instr, ~vecs[i].e_pc);
      end
      @(negedge clk);
    end

    // jr during WAIT with 3 wait states: old response drained and dropped.
    wait_n = 3;
    do_reset();
    #1; chk("jr_c0_addr", imem_addr, 32'h0000_3000);
    @(negedge clk);
    redir_sel = 2'b11; id_rs_val = 32'h0000_4000;
    #1; chk("jr_c1_addr", imem_addr, 32'h0000_3000);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("jr_drain_req", {31'd0, imem_req}, 32'd1);
    chk("jr_drain_addr", imem_addr, 32'h0000_3000);
    chk("jr_drain_valid", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    chk("jr_drain2_addr", imem_addr, 32'h0000_3000);
    @(negedge clk); #1;
    chk("jr_new_addr", imem_addr, 32'h0000_4000);
    chk("jr_new_valid", {31'd0, if_id_valid}, 32'd0);
    wait_valid("jr_wait", 20, found);
    if (found) begin
      chk("jr_first_pc", if_id_pc, 32'h0000_4000);
      chk("jr_first_instr", if_id_instr, ~32'h0000_4000);
    end

    // Stall during WAIT: response parked in skid, released when stall drops.
    wait_n = 2;
    do_reset();
    #1; chk("sk_c0_addr", imem_addr, 32'h0000_3000);
    @(negedge clk);
    stall = 1'b1;
    #1; chk("sk_c1_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk); #1;
    chk("sk_c2_valid", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    chk("sk_c3_req", {31'd0, imem_req}, 32'd0);
    chk("sk_c3_valid", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk);
    stall = 1'b0;
    #1; chk("sk_c4_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk); #1;
    chk("sk_c5_valid", {31'd0, if_id_valid}, 32'd1);
    chk("sk_c5_pc", if_id_pc, 32'h0000_3000);
    chk("sk_c5_instr", if_id_instr, ~32'h0000_3000);
    chk("sk_c5_addr", imem_addr, 32'h0000_3004);
    @(negedge clk); #1;
    chk("sk_c6_valid", {31'd0, if_id_valid}, 32'd0);
    wait_valid("sk_next_wait", 10, found);
    if (found) chk("sk_next_pc", if_id_pc, 32'h0000_3004);

    // jr to a misaligned target.
    wait_n = 0;
    do_reset();
    redir_sel = 2'b11; id_rs_val = 32'h0000_4002;
    #1; chk("al_c0_addr", imem_addr, 32'h0000_3000);
    @(negedge clk);
    idle_inputs();
    #1;
`ifdef ALIGN_CHECK_EN
    chk("al_err", {31'd0, fetch_err}, 32'd1);
    chk("al_valid", {31'd0, if_id_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("al_halt_req%0d", k), {31'd0, imem_req}, 32'd0);
      @(negedge clk); #1;
    end
    chk("al_err_sticky", {31'd0, fetch_err}, 32'd1);
`else
    chk("al_err", {31'd0, fetch_err}, 32'd0);
    chk("al_addr", imem_addr, 32'h0000_4000);
    chk("al_valid", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    chk("al_pc", if_id_pc, 32'h0000_4000);
    chk("al_valid2", {31'd0, if_id_valid}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
